// File: rtl/img_process.sv
// In-place 64x64 RGB image pipeline: vertical mirror, then grayscale, then a 3x3 sharpen on G.
// Drives an external combinational-read / clocked-write image memory through row/col/we/out_pix.
module img_process #(
   parameter int DIM  = 64,
   parameter int PIXW = 24,
   localparam int AW  = $clog2(DIM)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PIXW-1:0] in_pix,
   output logic [AW-1:0]   row,
   output logic [AW-1:0]   col,
   output logic            we,
   output logic [PIXW-1:0] out_pix,
   output logic            mirror_done,
   output logic            gray_done,
   output logic            filter_done
);

   typedef enum logic [2:0] {S_MIRROR, S_GRAY, S_FILT1, S_FILT2, S_DONE} state_t;
   typedef struct packed {
      logic          v;
      logic [AW-1:0] r;
      logic [AW-1:0] c;
   } nb_t;

   localparam logic [AW-1:0] LAST = AW'(DIM - 1);

   state_t                st;
   logic [1:0]            ph;
   logic [AW-2:0]         mr, mr_inc;
   logic [PIXW-1:0]       top, out_q, gray_pix;
   logic [3:0]            k;
   logic [AW-1:0]         pr, pc, npr, npc;
   logic signed [12:0]    acc, acc_nxt, g13, term;
   logic [7:0]            gc, clamp8, mx, mn;
   logic [8:0]            sum;
   nb_t                   cur, nxt_slot, nxt_pix;

   // Slot 0..8 walks the 3x3 window row-major; off-image slots come back invalid
   // and park the address on the centre pixel.
   function automatic nb_t nb(input logic [AW-1:0] r, input logic [AW-1:0] c,
                              input logic [3:0] slot);
      logic [1:0] dr, dc;
      logic [AW:0] nr, nc;
      nb_t o;
      dr  = (slot >= 4'd6) ? 2'd2 : (slot >= 4'd3) ? 2'd1 : 2'd0;
      dc  = 2'(slot - {1'b0, dr, 1'b0} - {2'b0, dr});
      nr  = {1'b0, r} + {{(AW-1){1'b0}}, dr} - (AW+1)'(1);
      nc  = {1'b0, c} + {{(AW-1){1'b0}}, dc} - (AW+1)'(1);
      o.v = (slot < 4'd9) && !nr[AW] && !nc[AW];
      o.r = o.v ? nr[AW-1:0] : r;
      o.c = o.v ? nc[AW-1:0] : c;
      return o;
   endfunction

   always_comb begin
      mr_inc   = mr + (AW-1)'(1);
      npc      = pc + AW'(1);
      npr      = (pc == LAST) ? pr + AW'(1) : pr;
      cur      = nb(pr, pc, k);
      nxt_slot = nb(pr, pc, k + 4'd1);
      nxt_pix  = nb(npr, npc, 4'd0);
   end

   always_comb begin
      mx = in_pix[23:16];
      mn = in_pix[23:16];
      if (in_pix[15:8] > mx) mx = in_pix[15:8];
      if (in_pix[7:0]  > mx) mx = in_pix[7:0];
      if (in_pix[15:8] < mn) mn = in_pix[15:8];
      if (in_pix[7:0]  < mn) mn = in_pix[7:0];
      sum      = {1'b0, mx} + {1'b0, mn};
      gray_pix = {8'd0, sum[8:1], 8'd0};
   end

   always_comb begin
      g13     = $signed({5'd0, in_pix[15:8]});
      term    = !cur.v ? 13'sd0 : (k == 4'd4) ? (g13 <<< 3) + g13 : -g13;
      acc_nxt = acc + term;
      clamp8  = acc_nxt[12] ? 8'd0 : (acc_nxt > 13'sd255) ? 8'hFF : acc_nxt[7:0];
   end

   // Single-cycle-per-pixel phases write a function of the pixel being read right now.
   always_comb begin
      case (st)
         S_GRAY:  out_pix = gray_pix;
         S_FILT2: out_pix = {8'd0, in_pix[7:0], 8'd0};
         default: out_pix = out_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= S_MIRROR; ph <= '0; mr <= '0; row <= '0; col <= '0; we <= 1'b0;
         out_q <= '0; top <= '0; k <= '0; pr <= '0; pc <= '0; acc <= '0; gc <= '0;
         mirror_done <= 1'b0; gray_done <= 1'b0; filter_done <= 1'b0;
      end else begin
         mirror_done <= 1'b0;
         gray_done   <= 1'b0;
         filter_done <= 1'b0;
         case (st)
            S_MIRROR: begin
               ph <= ph + 2'd1;
               case (ph)
                  2'd0: begin top <= in_pix; row <= {1'b1, ~mr}; end
                  2'd1: begin out_q <= in_pix; row <= {1'b0, mr}; we <= 1'b1; end
                  2'd2: begin out_q <= top; row <= {1'b1, ~mr}; end
                  default: begin
                     we  <= 1'b0;
                     col <= col + AW'(1);
                     row <= {1'b0, mr};
                     if (col == LAST) begin
                        mr  <= mr_inc;
                        row <= {1'b0, mr_inc};
                        if (mr == '1) begin
                           st <= S_GRAY; row <= '0; we <= 1'b1; mirror_done <= 1'b1;
                        end
                     end
                  end
               endcase
            end
            S_GRAY: begin
               col <= col + AW'(1);
               if (col == LAST) row <= row + AW'(1);
               if (row == LAST && col == LAST) begin
                  st <= S_FILT1; we <= 1'b0; gray_done <= 1'b1;
                  k <= '0; pr <= '0; pc <= '0; acc <= '0;
               end
            end
            S_FILT1: begin
               if (k != 4'd9) begin
                  acc <= acc_nxt;
                  k   <= k + 4'd1;
                  row <= nxt_slot.r;
                  col <= nxt_slot.c;
                  if (k == 4'd4) gc <= in_pix[15:8];
                  if (k == 4'd8) begin
                     we    <= 1'b1;
                     out_q <= {8'd0, gc, clamp8};
                  end
               end else begin
                  we <= 1'b0; acc <= '0; k <= '0;
                  pr <= npr; pc <= npc; row <= nxt_pix.r; col <= nxt_pix.c;
                  if (pr == LAST && pc == LAST) begin
                     st <= S_FILT2; we <= 1'b1; row <= '0; col <= '0;
                  end
               end
            end
            S_FILT2: begin
               if (row == LAST && col == LAST) begin
                  st <= S_DONE; we <= 1'b0; filter_done <= 1'b1;
               end else begin
                  col <= col + AW'(1);
                  if (col == LAST) row <= row + AW'(1);
               end
            end
            default: we <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_img_process.sv
// Bench for img_process: behavioural image memory, phase-tagged scoreboard checked on each done pulse.
module tb_img_process;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] in_pix, out_pix;
   logic [5:0]  row, col;
   logic        we, mirror_done, gray_done, filter_done;

   always #5 clk = ~clk;

   img_process dut (
      .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .row(row), .col(col), .we(we),
      .out_pix(out_pix), .mirror_done(mirror_done), .gray_done(gray_done),
      .filter_done(filter_done)
   );

   logic [23:0] mem [64][64];
   logic        load_req = 1'b0;
   int          load_kind = 0;
   int          errors = 0, checks = 0;
   int          cyc;

   typedef struct {
      int          ph;
      int          r;
      int          c;
      logic [23:0] exp;
      string       nm;
   } exp_t;
   exp_t sb[$];

   // Filter image: G=128 everywhere except a zero 5x5 block around a single 255 spike at (10,10).
   function automatic logic [7:0] filt_g(input int r, input int c);
      if (r == 10 && c == 10) return 8'd255;
      if (r >= 8 && r <= 12 && c >= 8 && c <= 12) return 8'd0;
      return 8'd128;
   endfunction

   always @(posedge clk or posedge load_req) begin
      if (load_req) begin
         for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
               if (load_kind == 0) mem[r][c] <= {r[7:0], c[7:0], 8'd0};
               else if (load_kind == 2) mem[r][c] <= {8'h11, filt_g(r, c), 8'h22};
            end
         if (load_kind == 1) begin
            mem[0][0] <= 24'hC86432;
            mem[0][1] <= 24'hFFFFFF;
            mem[0][2] <= 24'h000000;
         end
      end else if (we) begin
         mem[row][col] <= out_pix;
      end
   end

   assign in_pix = mem[row][col];

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int ph, input int r, input int c, input logic [23:0] e,
                       input string nm);
      exp_t x;
      x.ph = ph; x.r = r; x.c = c; x.exp = e; x.nm = nm;
      sb.push_back(x);
   endtask

   task automatic do_load(input int k);
      load_kind = k;
      load_req  = 1'b1;
      #1;
      load_req  = 1'b0;
   endtask

   task automatic wait_flag(input int which, input int budget, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = (which == 0) ? mirror_done : (which == 1) ? gray_done : filter_done;
      end
      chk(nm, 64'(seen), 64'd1);
   endtask

   // Monitor: on every done pulse, check sequencing then pop that phase's expectations.
   bit     mon_en = 1'b0;
   bit     prev_any = 1'b0, any_d;
   int     next_ph = 0, ph_d;
   exp_t   e_d;

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         any_d = mirror_done | gray_done | filter_done;
         if (any_d) begin
            ph_d = mirror_done ? 0 : gray_done ? 1 : 2;
            chk("done_onehot", 64'($countones({mirror_done, gray_done, filter_done})), 64'd1);
            chk("done_order", 64'(ph_d), 64'(next_ph));
            chk("done_width", 64'(prev_any), 64'd0);
            if (ph_d == 0) chk("mirror_cycles", 64'(cyc), 64'd8192);
            next_ph++;
            while (sb.size() > 0 && sb[0].ph == ph_d) begin
               e_d = sb.pop_front();
               chk(e_d.nm, 64'(mem[e_d.r][e_d.c]), 64'(e_d.exp));
            end
         end
         prev_any = any_d;
      end
   end

   initial begin
      bit bad;
      #1;
      do_load(0);
      repeat (3) @(negedge clk);
      chk("reset_state", 64'({row, col, we, out_pix, mirror_done, gray_done, filter_done}), 64'd0);
      rst_n = 1'b1;

      // Run A: abort mid-GRAY with an asynchronous reset
      wait_flag(0, 9000, "run_a_mirror_timeout");
      repeat (100) @(posedge clk);
      #2;
      chk("gray_we_active", 64'(we), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          64'({row, col, we, out_pix, mirror_done, gray_done, filter_done}), 64'd0);
      repeat (3) @(negedge clk);

      // Run B: full run with all phase checks
      do_load(0);
      push(0, 0, 5, 24'h3F0500, "mirror_0_5");
      push(0, 63, 5, 24'h000500, "mirror_63_5");
      push(0, 31, 0, 24'h200000, "mirror_31_0");
      push(0, 32, 63, 24'h1F3F00, "mirror_32_63");
      mon_en = 1'b1;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_bottom_read", 64'({row, col, we}), 64'({6'd63, 6'd0, 1'b0}));

      wait_flag(0, 9000, "mirror_timeout");
      @(negedge clk);
      #1;
      do_load(1);
      push(1, 0, 0, 24'h007D00, "gray_200_100_50");
      push(1, 0, 1, 24'h00FF00, "gray_white");
      push(1, 0, 2, 24'h000000, "gray_black");
      push(1, 5, 7, 24'h001D00, "gray_5_7");
      push(1, 60, 40, 24'h001400, "gray_60_40");

      wait_flag(1, 4200, "gray_timeout");
      @(negedge clk);
      #1;
      do_load(2);
      push(2, 30, 30, 24'h008000, "filt_uniform_interior");
      push(2, 0, 0, 24'h00FF00, "filt_corner_0_0");
      push(2, 63, 63, 24'h00FF00, "filt_corner_63_63");
      push(2, 0, 30, 24'h00FF00, "filt_edge_0_30");
      push(2, 10, 10, 24'h00FF00, "filt_spike");
      push(2, 9, 9, 24'h000000, "filt_spike_nb_9_9");
      push(2, 11, 10, 24'h000000, "filt_spike_nb_11_10");
      push(2, 10, 11, 24'h000000, "filt_spike_nb_10_11");
      push(2, 7, 10, 24'h00FF00, "filt_7_10");

      wait_flag(2, 46000, "filter_timeout");
      bad = 1'b0;
      repeat (16) begin
         @(posedge clk);
         #1;
         if (we || row != 6'd63 || col != 6'd63 || mirror_done || gray_done || filter_done)
            bad = 1'b1;
      end
      chk("idle_after_done", 64'(bad), 64'd0);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      chk("done_count", 64'(next_ph), 64'd3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
